// File: rtl/ewb_queue.sv
// External write buffer between the L2 memory side and physical memory: queues victim
// writebacks, forwards hits, lets misses bypass. Optional coalescing via EWB_COALESCE_EN.
module ewb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cache_read,
  input  logic                       cache_write,
  input  logic [ADDR_W-1:0]          cache_addr,
  input  logic [LINE_W-1:0]          cache_wdata,
  output logic                       cache_resp,
  output logic [LINE_W-1:0]          cache_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_resp,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                ewb_writes_count,
  input  logic                       ewb_writes_reset
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [DEPTH-1:0]    valid;
  logic [ADDR_W-1:0]   line_addr [DEPTH];
  logic [LINE_W-1:0]   line_data [DEPTH];
  logic                resp_q;
  logic [LINE_W-1:0]   rdata_q;

  logic [ADDR_W-1:0]   req_line;
  logic                full;
  logic                rd_hit;
  logic [PTR_W-1:0]    rd_idx;
  logic                co_hit;
  logic [PTR_W-1:0]    co_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic                wr_accept;
  logic [PTR_W-1:0]    wr_idx;
  logic                rd_done;
  logic                pop;

  assign req_line = cache_addr & LINE_MASK;
  assign full     = (count == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = head;
    co_hit   = 1'b0;
    co_idx   = head;
    scan_idx = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (valid[scan_idx] && (line_addr[scan_idx] == req_line)) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
`ifdef EWB_COALESCE_EN
        if (!((state == WR) && (scan_idx == head))) begin
          co_hit = 1'b1;
          co_idx = scan_idx;
        end
`endif
      end
    end
  end

  assign wr_accept = (state == IDLE) && !cache_read && cache_write && (co_hit || !full);
  assign wr_idx    = co_hit ? co_idx : tail;
  assign rd_done   = (state == RD) && mem_resp;
  assign pop       = (state == WR) && mem_resp;

  // Miss data is passed straight through in the mem_resp cycle.
  assign cache_resp  = resp_q | rd_done;
  assign cache_rdata = rd_done ? mem_rdata : rdata_q;
  assign occupancy   = count;

  // Line payload storage; not reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      line_data[wr_idx] <= cache_wdata;
    end
  end

  // Control FSM, queue pointers and registered downstream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid       <= '0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_addr[i] <= '0;
      end
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cache_read && rd_hit) begin
            rdata_q <= line_data[rd_idx];
            resp_q  <= 1'b1;
            state   <= RESP;
          end else if (cache_read) begin
            mem_read    <= 1'b1;
            mem_address <= req_line;
            state       <= RD;
          end else if (wr_accept) begin
            if (!co_hit) begin
              valid[tail]     <= 1'b1;
              line_addr[tail] <= req_line;
              tail            <= tail + PTR_W'(1);
              count           <= count + CNT_W'(1);
            end
            resp_q <= 1'b1;
            state  <= RESP;
          end else if (count != '0) begin
            mem_write   <= 1'b1;
            mem_address <= line_addr[head];
            mem_wdata   <= line_data[head];
            state       <= WR;
          end
        end
        RD: begin
          if (mem_resp) begin
            mem_read    <= 1'b0;
            mem_address <= '0;
            state       <= RESP;
          end
        end
        WR: begin
          if (mem_resp) begin
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
            count       <= count - CNT_W'(1);
            state       <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completed-drain counter; software clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ewb_writes_count <= '0;
    end else if (ewb_writes_reset) begin
      ewb_writes_count <= '0;
    end else if (pop) begin
      ewb_writes_count <= ewb_writes_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ewb_queue.sv
// Directed bench for ewb_queue: vector table for buffered hits/allocation/bypass,
// hand sequences for drain, full stall, counter clear and mid-drain reset.
module tb_ewb_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
`ifdef EWB_COALESCE_EN
  localparam int COAL = 1;
`else
  localparam int COAL = 0;
`endif

  typedef logic [LINE_W-1:0] line_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    line_t             data;
    logic              hold;
    int                lat;
    logic              chk_rd;
    line_t             rdata;
    int                occ;
    int                nrd;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] cache_addr;
  line_t             cache_wdata;
  logic              cache_resp;
  line_t             cache_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  line_t             mem_wdata;
  line_t             mem_rdata;
  logic              mem_resp;
  logic [OCC_W-1:0]  occupancy;
  logic [31:0]       ewb_writes_count;
  logic              ewb_writes_reset;

  ewb_queue #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .cache_read       (cache_read),
    .cache_write      (cache_write),
    .cache_addr       (cache_addr),
    .cache_wdata      (cache_wdata),
    .cache_resp       (cache_resp),
    .cache_rdata      (cache_rdata),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .occupancy        (occupancy),
    .ewb_writes_count (ewb_writes_count),
    .ewb_writes_reset (ewb_writes_reset)
  );

  always #5 clk = ~clk;

  int                n_vec;
  int                n_fail;
  int                n_reads;
  int                n_wr;
  int                n_drains;
  int                n_resp;
  logic              mem_hold;
  logic [ADDR_W-1:0] last_rd_addr;
  logic [ADDR_W-1:0] last_dr_addr;
  line_t             last_dr_data;
  vec_t              vecs [7];

  function automatic line_t mk(input logic [31:0] x);
    return {8{x}};
  endfunction

  function automatic line_t rd_pattern(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input line_t got, input line_t exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: memory model answers at posedge+1, outputs observed at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_resp  = (mem_read || mem_write) && !mem_hold;
    mem_rdata = mem_resp ? rd_pattern(mem_address) : '0;
    @(negedge clk);
    if (mem_read) begin
      n_reads++;
      last_rd_addr = mem_address;
    end
    if (mem_write) n_wr++;
    if (mem_write && mem_resp) begin
      n_drains++;
      last_dr_addr = mem_address;
      last_dr_data = mem_wdata;
    end
    if (cache_resp) n_resp++;
  endtask

  task automatic request(input logic wr, input logic [ADDR_W-1:0] addr, input line_t wd,
                         input int max_cyc, output int lat, output line_t rd);
    cache_read  = !wr;
    cache_write = wr;
    cache_addr  = addr;
    cache_wdata = wd;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (cache_resp) begin
        lat = i;
        rd  = cache_rdata;
        break;
      end
    end
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    lat;
    int    k;
    int    r0;
    line_t rd;

    n_vec = 0; n_fail = 0; n_reads = 0; n_wr = 0; n_drains = 0; n_resp = 0;
    last_rd_addr = '0; last_dr_addr = '0; last_dr_data = '0;
    rst = 1'b1; cache_read = 1'b0; cache_write = 1'b0; cache_addr = '0; cache_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0; ewb_writes_reset = 1'b0; mem_hold = 1'b1;

    vecs[0] = '{wr:1'b1, addr:32'h100, data:mk(32'hD1D1_0001), hold:1'b1, lat:1,
                chk_rd:1'b0, rdata:'0, occ:1, nrd:0};
    vecs[1] = '{wr:1'b1, addr:32'h100, data:mk(32'hD2D2_0002), hold:1'b1, lat:1,
                chk_rd:1'b0, rdata:'0, occ:2 - COAL, nrd:0};
    vecs[2] = '{wr:1'b0, addr:32'h104, data:'0, hold:1'b1, lat:1,
                chk_rd:1'b1, rdata:mk(32'hD2D2_0002), occ:2 - COAL, nrd:0};
    vecs[3] = '{wr:1'b1, addr:32'h300, data:mk(32'hD3D3_0003), hold:1'b1, lat:1,
                chk_rd:1'b0, rdata:'0, occ:3 - COAL, nrd:0};
    vecs[4] = '{wr:1'b0, addr:32'h300, data:'0, hold:1'b1, lat:1,
                chk_rd:1'b1, rdata:mk(32'hD3D3_0003), occ:3 - COAL, nrd:0};
    vecs[5] = '{wr:1'b0, addr:32'h11F, data:'0, hold:1'b1, lat:1,
                chk_rd:1'b1, rdata:mk(32'hD2D2_0002), occ:3 - COAL, nrd:0};
    vecs[6] = '{wr:1'b0, addr:32'h21F, data:'0, hold:1'b0, lat:1,
                chk_rd:1'b1, rdata:rd_pattern(32'h200), occ:3 - COAL, nrd:1};

    // Reset values
    #3;
    chk("rst cache_resp", line_t'(cache_resp), '0);
    chk("rst cache_rdata", cache_rdata, '0);
    chk("rst mem_read", line_t'(mem_read), '0);
    chk("rst mem_write", line_t'(mem_write), '0);
    chk("rst mem_address", line_t'(mem_address), '0);
    chk("rst mem_wdata", mem_wdata, '0);
    chk("rst occupancy", line_t'(occupancy), '0);
    chk("rst count", line_t'(ewb_writes_count), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;

    // Idle for 10 cycles: nothing moves
    for (int i = 0; i < 10; i++) tick();
    chk("idle mem_read cycles", line_t'(n_reads), '0);
    chk("idle mem_write cycles", line_t'(n_wr), '0);
    chk("idle cache_resp cycles", line_t'(n_resp), '0);
    chk("idle occupancy", line_t'(occupancy), '0);

    // Single write, then drain
    request(1'b1, 32'h100, mk(32'hD1D1_0001), 8, lat, rd);
    chk("wr1 latency", line_t'(lat), line_t'(1));
    chk("wr1 occupancy", line_t'(occupancy), line_t'(1));
    r0 = n_drains;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (n_drains != r0) begin
        k = i;
        break;
      end
    end
    chk("drain1 cycle after resp", line_t'(k), line_t'(2));
    chk("drain1 address", line_t'(last_dr_addr), line_t'(32'h100));
    chk("drain1 data", last_dr_data, mk(32'hD1D1_0001));
    tick();
    chk("drain1 occupancy", line_t'(occupancy), '0);
    chk("drain1 count", line_t'(ewb_writes_count), line_t'(1));

    // Table: allocation/coalesce, forwarding, bypass read
    n_reads = 0;
    for (int i = 0; i < 7; i++) begin
      mem_hold = vecs[i].hold;
      request(vecs[i].wr, vecs[i].addr, vecs[i].data, 8, lat, rd);
      chk($sformatf("v%0d latency", i), line_t'(lat), line_t'(vecs[i].lat));
      if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d occupancy", i), line_t'(occupancy), line_t'(vecs[i].occ));
      chk($sformatf("v%0d mem_read cycles", i), line_t'(n_reads), line_t'(vecs[i].nrd));
      tick();
    end
    chk("bypass mem_address", line_t'(last_rd_addr), line_t'(32'h200));

    // Let the queue drain completely
    mem_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (occupancy == '0) break;
      tick();
    end
    chk("table drain occupancy", line_t'(occupancy), '0);
    chk("table drain count", line_t'(ewb_writes_count), line_t'(1 + 3 - COAL));
    chk("table last drain addr", line_t'(last_dr_addr), line_t'(32'h300));
    chk("table last drain data", last_dr_data, mk(32'hD3D3_0003));
    tick();

    // Fill the buffer with drains held off
    mem_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      request(1'b1, 32'(i) << 12, mk(32'hF000_0000 + 32'(i)), 8, lat, rd);
      chk($sformatf("fill%0d latency", i), line_t'(lat), line_t'(1));
      tick();
    end
    chk("full occupancy", line_t'(occupancy), line_t'(4));

    // Fifth write stalls until a drain pops
    cache_write = 1'b1;
    cache_addr  = 32'h5000;
    cache_wdata = mk(32'hF000_0005);
    r0 = n_resp;
    for (int i = 0; i < 6; i++) tick();
    chk("full write stalled", line_t'(n_resp - r0), '0);
    chk("full drain in flight", line_t'(mem_write), line_t'(1));

    // Release one drain with a counter clear held across the pop edge
    mem_hold = 1'b0;
    ewb_writes_reset = 1'b1;
    k = -1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) ewb_writes_reset = 1'b0;
      tick();
      if (cache_resp) begin
        k = i;
        break;
      end
    end
    ewb_writes_reset = 1'b0;
    mem_hold    = 1'b1;
    cache_write = 1'b0;
    chk("stalled write accept cycle", line_t'(k), line_t'(3));
    chk("after accept occupancy", line_t'(occupancy), line_t'(4));
    chk("clear beats increment", line_t'(ewb_writes_count), '0);

    // One more drain so three entries remain with a drain in flight
    tick();
    tick();
    mem_hold = 1'b0;
    tick();
    mem_hold = 1'b1;
    tick();
    tick();
    chk("pre-reset occupancy", line_t'(occupancy), line_t'(3));
    chk("pre-reset mem_write", line_t'(mem_write), line_t'(1));
    chk("pre-reset count", line_t'(ewb_writes_count), line_t'(1));

    // Asynchronous reset in the middle of a drain
    #2;
    rst = 1'b1;
    #1;
    chk("async rst mem_write", line_t'(mem_write), '0);
    chk("async rst mem_address", line_t'(mem_address), '0);
    chk("async rst occupancy", line_t'(occupancy), '0);
    chk("async rst count", line_t'(ewb_writes_count), '0);
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    r0 = n_wr;
    for (int i = 0; i < 8; i++) tick();
    chk("post-reset no drains", line_t'(n_wr - r0), '0);
    chk("post-reset occupancy", line_t'(occupancy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ewb_queue.md
# ewb_queue

Parametrised external write buffer with integrated downstream arbitration. Sits between the L2 cache's physical-memory side and physical memory. It absorbs L2 victim writebacks into a DEPTH-entry FIFO, forwards read data from buffered lines, and lets L2 miss reads bypass queued writes. Queued writes drain to memory whenever no read is outstanding.

## Interface
Parameters:
- DEPTH, 4: number of line entries; power of two, 2..16.
- LINE_W, 256: line width in bits.
- ADDR_W, 32: address width; line offset bits = $clog2(LINE_W/8), ignored in all compares and zeroed on mem_address.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- cache_read  in  1  L2 line read request; held until cache_resp.
- cache_write  in  1  L2 line writeback request; held until cache_resp; never asserted with cache_read.
- cache_addr  in  ADDR_W  request address.
- cache_wdata  in  LINE_W  writeback data.
- cache_resp  out  1  one-cycle completion pulse.
- cache_rdata  out  LINE_W  read data; valid while cache_resp=1 for reads.
- mem_read  out  1  downstream line read.
- mem_write  out  1  downstream line write (drain).
- mem_address  out  ADDR_W  downstream address, offset bits zero.
- mem_wdata  out  LINE_W  drain data.
- mem_rdata  in  LINE_W  downstream read data.
- mem_resp  in  1  downstream completion.
- occupancy  out  $clog2(DEPTH+1)  valid entries.
- ewb_writes_count  out  32  drains completed since reset/clear.
- ewb_writes_reset  in  1  synchronous clear of ewb_writes_count.

## Operation
- Storage: circular FIFO of {valid, line address, data}; head/tail pointers wrap modulo DEPTH.
- FSM states: IDLE, RD (downstream read in flight), WR (head drain in flight), RESP (one-cycle response to a buffered hit/accept).
- IDLE priority, evaluated each cycle:
  - 1: cache_read matching a valid entry goes to RESP; youngest match wins, cache_rdata registered from that entry.
  - 2: cache_read with no match goes to RD.
  - 3: cache_write, not full, allocates or coalesces, then goes to RESP.
  - 4: occupancy>0 goes to WR.
  - 5: otherwise stays IDLE.
- cache_write when full with no coalesce target: not accepted. Drain proceeds (priority 4); the write is accepted in IDLE after the pop.
- RD: mem_read=1 and mem_address=cache_addr until mem_resp. In the mem_resp cycle, cache_resp=1 and cache_rdata=mem_rdata combinationally; next state RESP.
- WR: mem_write=1 with head address/data until mem_resp. On mem_resp: pop head, increment ewb_writes_count, return to IDLE. The head entry is locked while in WR.
- RESP: cache_resp=1 for hit/accept (not after RD, where resp was already given). Requests are ignored this cycle; next state IDLE.
- A write accept and a pop never occur in the same cycle; occupancy changes by at most 1 per cycle.
- ewb_writes_reset has priority over an increment in the same cycle; the counter wraps at 2^32.

## Timing
- Reset values: all entries invalid, pointers 0, state IDLE. All outputs 0, ewb_writes_count=0.
- Buffer read hit and write accept: cache_resp one cycle after the request is sampled in IDLE.
- Miss read: cache_resp in the same cycle as mem_resp.
- A read arriving during WR waits for the drain to finish. It does not abort the drain.
- Reset mid-operation: in-flight drain and buffered lines are discarded, and mem_read/mem_write drop immediately.

## Configuration
- EWB_COALESCE_EN defined: a write whose line address matches a valid, unlocked entry overwrites that entry's data in place. Occupancy is unchanged and no slot is needed, even when full.
- EWB_COALESCE_EN undefined: every accepted write allocates a new tail entry. Read forwarding still returns the youngest match.

## Test plan
- Reset then idle: all outputs 0, occupancy=0, no mem_read/mem_write for 10 cycles.
- Write A=0x100 with data D1: cache_resp at T+1. Next IDLE cycle: mem_write with address 0x100 and D1. After mem_resp: occupancy=0, ewb_writes_count=1.
- Fill DEPTH=4 with distinct lines while holding mem_resp low, then issue a 5th write: no cache_resp until the first drain's mem_resp. Write accepted afterwards; occupancy returns to 4.
- Write A with D1, write A with D2, then read A with mem_resp held off:
  - With EWB_COALESCE_EN: occupancy=1 and read returns D2.
  - Without it: occupancy=2 and read returns D2.
  - In both cases no mem_read is issued.
- Read B=0x200 absent from a buffer holding 2 entries: mem_read with address 0x200 issued before any drain. cache_resp and cache_rdata=mem_rdata in the mem_resp cycle.
- Assert rst during WR with 3 entries: mem_write drops asynchronously, occupancy=0, ewb_writes_count=0.
